// File: rtl/noc_empty_node.sv
// ============================================================================
// Module   : noc_empty_node
// Purpose  : Terminating endpoint for an unused NoC router local port.
//            Always-ready sink with framing checks and flit/packet counters;
//            define NOC_EMPTY_NODE_ECHO_EN to echo packets back to their source.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module noc_empty_node #(
  parameter int DATA_WIDTH = 32,
  parameter int COORD_W    = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic                  receive_valid,
  output logic                  receive_ready,
  input  logic [DATA_WIDTH-1:0] receive_flit,
  input  logic                  receive_is_header,
  input  logic                  receive_is_tail,
  output logic                  sender_valid,
  input  logic                  sender_ready,
  output logic [DATA_WIDTH-1:0] sender_flit,
  output logic                  sender_is_header,
  output logic                  sender_is_tail,
  output logic [CNT_W-1:0]      rx_pkt_count,
  output logic [CNT_W-1:0]      rx_flit_count,
  output logic                  frame_error
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_e;

  state_e           state_q;
  logic             ready_q;
  logic [CNT_W-1:0] rx_pkt_q;
  logic [CNT_W-1:0] rx_flit_q;
  logic             frame_err_q;
  logic             accept_ready_w;
  logic             rx_fire_w;
  logic             violation_w;

  assign receive_ready = accept_ready_w;
  assign rx_fire_w     = receive_valid & accept_ready_w;
  assign violation_w   = (state_q == IDLE)   ? ~receive_is_header
                                             :  receive_is_header;

  // Framing, statistics and the post-reset ready enable.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rx_pkt_q    <= '0;
      rx_flit_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (rx_fire_w) begin
        rx_flit_q <= rx_flit_q + CNT_W'(1);
        if (receive_is_tail) begin
          rx_pkt_q <= rx_pkt_q + CNT_W'(1);
        end
        if (violation_w) begin
          frame_err_q <= 1'b1;
        end
        // A header always (re)starts framing, so a misplaced header opens a new packet.
        if (receive_is_tail) begin
          state_q <= IDLE;
        end else if (receive_is_header) begin
          state_q <= IN_PKT;
        end
      end
    end
  end

  assign rx_pkt_count  = rx_pkt_q;
  assign rx_flit_count = rx_flit_q;
  assign frame_error   = frame_err_q;

`ifdef NOC_EMPTY_NODE_ECHO_EN

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH+1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           count_q;
  logic                  full_w;
  logic                  empty_w;
  logic                  pop_w;
  logic [DATA_WIDTH-1:0] echo_flit_w;
  logic [DATA_WIDTH+1:0] head_w;

  assign full_w         = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty_w        = (count_q == '0);
  assign accept_ready_w = ready_q & ~full_w;
  assign pop_w          = ~empty_w & sender_ready;

  // Swap the (x,y) source and destination pairs so the echo returns home.
  always_comb begin
    echo_flit_w = receive_flit;
    if (receive_is_header) begin
      echo_flit_w[2*COORD_W-1:0]         = receive_flit[4*COORD_W-1:2*COORD_W];
      echo_flit_w[4*COORD_W-1:2*COORD_W] = receive_flit[2*COORD_W-1:0];
    end
  end

  always_ff @(posedge noc_clk) begin
    if (rx_fire_w) begin
      mem_q[wr_ptr_q] <= {receive_is_header, receive_is_tail, echo_flit_w};
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (rx_fire_w) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_w) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({rx_fire_w, pop_w})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_w           = mem_q[rd_ptr_q];
  assign sender_valid     = ~empty_w;
  assign sender_flit      = empty_w ? '0   : head_w[DATA_WIDTH-1:0];
  assign sender_is_header = empty_w ? 1'b0 : head_w[DATA_WIDTH+1];
  assign sender_is_tail   = empty_w ? 1'b0 : head_w[DATA_WIDTH];

`else

  logic unused_sink_w;

  assign accept_ready_w   = ready_q;
  assign sender_valid     = 1'b0;
  assign sender_flit      = '0;
  assign sender_is_header = 1'b0;
  assign sender_is_tail   = 1'b0;
  assign unused_sink_w    = ^{sender_ready, receive_flit, 32'(COORD_W), 32'(FIFO_DEPTH)};

`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_empty_node.sv
// ============================================================================
// Module   : tb_noc_empty_node
// Purpose  : Directed plus randomized bench for noc_empty_node, checked against
//            a queue-based reference model; follows NOC_EMPTY_NODE_ECHO_EN.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_noc_empty_node;

  localparam int DW    = 32;
  localparam int CW    = 2;
  localparam int DEPTH = 8;
  localparam int CNTW  = 16;

  logic            noc_clk = 1'b0;
  logic            noc_rst_n;
  logic            receive_valid;
  logic            receive_ready;
  logic [DW-1:0]   receive_flit;
  logic            receive_is_header;
  logic            receive_is_tail;
  logic            sender_valid;
  logic            sender_ready;
  logic [DW-1:0]   sender_flit;
  logic            sender_is_header;
  logic            sender_is_tail;
  logic [CNTW-1:0] rx_pkt_count;
  logic [CNTW-1:0] rx_flit_count;
  logic            frame_error;

  noc_empty_node #(
    .DATA_WIDTH (DW),
    .COORD_W    (CW),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNTW)
  ) dut (
    .noc_clk           (noc_clk),
    .noc_rst_n         (noc_rst_n),
    .receive_valid     (receive_valid),
    .receive_ready     (receive_ready),
    .receive_flit      (receive_flit),
    .receive_is_header (receive_is_header),
    .receive_is_tail   (receive_is_tail),
    .sender_valid      (sender_valid),
    .sender_ready      (sender_ready),
    .sender_flit       (sender_flit),
    .sender_is_header  (sender_is_header),
    .sender_is_tail    (sender_is_tail),
    .rx_pkt_count      (rx_pkt_count),
    .rx_flit_count     (rx_flit_count),
    .frame_error       (frame_error)
  );

  always #5 noc_clk = ~noc_clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: entries are {header, tail, flit} in the order they will be echoed.
  logic [DW+1:0] q [$];
  int unsigned   m_flits;
  int unsigned   m_pkts;
  bit            m_err;
  bit            m_inpkt;
  bit            m_live;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] swap_coords(input logic [DW-1:0] f);
    int unsigned mask, dx, dy, sx, sy;
    logic [DW-1:0] payload;
    mask    = (1 << CW) - 1;
    dx      = (f >> (0 * CW)) & mask;
    dy      = (f >> (1 * CW)) & mask;
    sx      = (f >> (2 * CW)) & mask;
    sy      = (f >> (3 * CW)) & mask;
    payload = (f >> (4 * CW)) << (4 * CW);
    return payload | DW'((dy << (3 * CW)) | (dx << (2 * CW)) | (sy << CW) | sx);
  endfunction

  function automatic bit exp_ready();
    if (!m_live) return 1'b0;
`ifdef NOC_EMPTY_NODE_ECHO_EN
    return q.size() < DEPTH;
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_reset();
    q.delete();
    m_flits = 0;
    m_pkts  = 0;
    m_err   = 1'b0;
    m_inpkt = 1'b0;
    m_live  = 1'b0;
  endfunction

  function automatic void model_accept(input logic [DW-1:0] f, input bit h, input bit t);
    m_flits = m_flits + 1;
    if (t) m_pkts = m_pkts + 1;
    if ((!m_inpkt && !h) || (m_inpkt && h)) m_err = 1'b1;
    if (t)      m_inpkt = 1'b0;
    else if (h) m_inpkt = 1'b1;
`ifdef NOC_EMPTY_NODE_ECHO_EN
    q.push_back({h, t, (h ? swap_coords(f) : f)});
`endif
  endfunction

  // One clock: compare outputs to the model, drive inputs, step past the edge, update model.
  task automatic cycle(input bit v, input logic [DW-1:0] f, input bit h, input bit t,
                       input bit sr, output bit acc);
    bit            rdy;
    bit            sv;
    logic [DW+1:0] head;
    rdy  = exp_ready();
    sv   = (q.size() != 0);
    head = sv ? q[0] : '0;
    chk("receive_ready", receive_ready, rdy);
    chk("sender_valid", sender_valid, sv);
    chk("sender_flit", sender_flit, head[DW-1:0]);
    chk("sender_is_header", sender_is_header, head[DW+1]);
    chk("sender_is_tail", sender_is_tail, head[DW]);
    chk("rx_flit_count", rx_flit_count, 64'(m_flits % (1 << CNTW)));
    chk("rx_pkt_count", rx_pkt_count, 64'(m_pkts % (1 << CNTW)));
    chk("frame_error", frame_error, m_err);
    receive_valid     = v;
    receive_flit      = f;
    receive_is_header = h;
    receive_is_tail   = t;
    sender_ready      = sr;
    acc = v && rdy;
    @(posedge noc_clk);
    #1;
    if (sv && sr) void'(q.pop_front());
    if (acc) model_accept(f, h, t);
    if (noc_rst_n) m_live = 1'b1;
  endtask

  initial begin
    bit            acc;
    bit            pending;
    bit            g_in;
    bit            hv, hh, ht, sr;
    logic [DW-1:0] hf;
    int            r;
    int            n_acc;
    int unsigned   base;

    noc_rst_n         = 1'b1;
    receive_valid     = 1'b0;
    receive_flit      = '0;
    receive_is_header = 1'b0;
    receive_is_tail   = 1'b0;
    sender_ready      = 1'b0;
    model_reset();

    // Reset pulse released at 100 ps, before the first rising edge.
    #0.02 noc_rst_n = 1'b0;
    #0.03;
    chk("rst_receive_ready", receive_ready, 1'b0);
    chk("rst_sender_valid", sender_valid, 1'b0);
    chk("rst_sender_flit", sender_flit, '0);
    chk("rst_sender_markers", {sender_is_header, sender_is_tail}, 2'b00);
    chk("rst_counts", {rx_pkt_count, rx_flit_count}, '0);
    chk("rst_frame_error", frame_error, 1'b0);
    #0.05 noc_rst_n = 1'b1;
    @(posedge noc_clk);
    #1;
    m_live = 1'b1;
    chk("first_edge_ready", receive_ready, 1'b1);

    // Well-formed three-flit packet.
    cycle(1'b1, 32'h0000_0012, 1'b1, 1'b0, 1'b1, acc);
    cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b1, 32'h9ABC_DEF0, 1'b0, 1'b1, 1'b1, acc);
    chk("pkt3_flits", rx_flit_count, 16'd3);
    chk("pkt3_pkts", rx_pkt_count, 16'd1);
    chk("pkt3_frame_error", frame_error, 1'b0);
`ifndef NOC_EMPTY_NODE_ECHO_EN
    chk("sink_sender_valid", sender_valid, 1'b0);
`endif

    // Body flit while idle is a violation; flag is sticky.
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, acc);
    chk("idle_body_error", frame_error, 1'b1);
    chk("idle_body_flits", rx_flit_count, 16'd4);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    chk("error_sticky", frame_error, 1'b1);

`ifdef NOC_EMPTY_NODE_ECHO_EN
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b1, 32'hAB00_00E4, 1'b1, 1'b1, 1'b0, acc);
    chk("echo_valid", sender_valid, 1'b1);
    chk("echo_swapped_flit", sender_flit, 32'hAB00_004E);
    chk("echo_markers", {sender_is_header, sender_is_tail}, 2'b11);
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);

    // Stall the sender and offer ten flits, holding each until taken.
    base  = m_flits;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 4; k++) begin
        cycle(1'b1, 32'hC0DE_0000 + 32'(i), (i == 0), 1'b0, 1'b0, acc);
        if (acc) break;
      end
      if (acc) n_acc = n_acc + 1;
    end
    chk("full_accepted", 64'(n_acc), 64'd8);
    chk("full_flit_count", rx_flit_count, 16'(base + 8));
    chk("full_ready_low", receive_ready, 1'b0);
    cycle(1'b1, 32'hC0DE_0008, 1'b0, 1'b0, 1'b1, acc);
    chk("ready_after_pop", receive_ready, 1'b1);
    cycle(1'b1, 32'hC0DE_0008, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b1, 32'hC0DE_0009, 1'b0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 30 && q.size() != 0; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
`endif

    // Reset in the middle of a packet with flits buffered.
    cycle(1'b1, 32'h5500_0021, 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h7777_0000, 1'b0, 1'b0, 1'b0, acc);
    receive_valid = 1'b0;
    noc_rst_n     = 1'b0;
    #1;
    chk("midrst_sender_valid", sender_valid, 1'b0);
    chk("midrst_ready", receive_ready, 1'b0);
    chk("midrst_counts", {rx_pkt_count, rx_flit_count}, '0);
    chk("midrst_frame_error", frame_error, 1'b0);
    model_reset();
    #2 noc_rst_n = 1'b1;
    @(posedge noc_clk);
    #1;
    m_live = 1'b1;
    cycle(1'b1, 32'h0000_00B1, 1'b1, 1'b0, 1'b1, acc);
    cycle(1'b1, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b1, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    chk("postrst_framing_idle", frame_error, 1'b0);
    chk("postrst_pkts", rx_pkt_count, 16'd1);

    // Randomized traffic with occasional long sender stalls and framing slips.
    pending = 1'b0;
    g_in    = 1'b0;
    hv = 1'b0; hh = 1'b0; ht = 1'b0; hf = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pending) begin
        hv = ($urandom_range(0, 9) < 7);
        hf = $urandom;
        r  = $urandom_range(0, 15);
        if (!g_in) begin
          hh = (r != 0);
          ht = (r < 6);
        end else begin
          hh = (r == 0);
          ht = (r < 5);
        end
      end
      sr = ((n % 64) < 20) ? 1'b0 : ($urandom_range(0, 3) != 0);
      cycle(hv, hf, hh, ht, sr, acc);
      pending = hv && !acc;
      if (acc) begin
        if (ht)      g_in = 1'b0;
        else if (hh) g_in = 1'b1;
      end
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/noc_empty_node.md
Name: noc_empty_node

Overview:
- Terminating endpoint for an unused router local port in the NoC mesh, e.g. a 2x2 mesh where nodes (0,1) and (1,0) carry no real IP.
- Attaches to one router port pair: its receive side takes the router's sender outputs, and its sender side drives the router's receive inputs.
- Default build: a well-behaved always-ready sink with packet-framing checks and statistics.
- Optional build: echoes every packet back to its source.

Parameters:
- DATA_WIDTH, 32, flit width; must equal the NoC flit width.
- COORD_W, 2, width of one mesh coordinate field in a header flit.
- FIFO_DEPTH, 8, echo buffer depth in flits; power of two, at least 2; used only with echo enabled.
- CNT_W, 16, width of the statistics counters.

Ports:
- noc_clk  in  1  NoC clock; everything is on the rising edge.
- noc_rst_n  in  1  asynchronous active-low reset.
- receive_valid  in  1  incoming flit valid.
- receive_ready  out  1  node can accept a flit.
- receive_flit  in  DATA_WIDTH  incoming flit.
- receive_is_header  in  1  first flit of a packet.
- receive_is_tail  in  1  last flit of a packet; header and tail both high means a single-flit packet.
- sender_valid  out  1  outgoing flit valid.
- sender_ready  in  1  router accepts the outgoing flit.
- sender_flit  out  DATA_WIDTH  outgoing flit.
- sender_is_header  out  1  outgoing header marker.
- sender_is_tail  out  1  outgoing tail marker.
- rx_pkt_count  out  CNT_W  tail flits accepted.
- rx_flit_count  out  CNT_W  flits accepted.
- frame_error  out  1  sticky protocol-violation flag.

Behaviour:
- Interface: one clock (noc_clk); reset is asynchronous and active-low (noc_rst_n).
- Reset values:
  - receive_ready = 0.
  - sender_valid, sender_flit, sender_is_header, sender_is_tail = 0.
  - Both counters = 0; frame_error = 0; framing state = IDLE.
  - Echo FIFO empty.
  - Reset asserted mid-packet discards all buffered flits and returns to IDLE immediately.
- Handshakes:
  - A receive transfer occurs on a rising edge where receive_valid and receive_ready are both 1.
  - A send transfer occurs where sender_valid and sender_ready are both 1.
  - While valid is high and ready is low, the source holds its flit and markers stable.
- Framing FSM, states IDLE and IN_PKT, advanced on each accepted flit:
  - IDLE + header, not tail -> IN_PKT.
  - IDLE + header + tail -> IDLE; counts as a packet.
  - IN_PKT + tail, not header -> IDLE.
  - IN_PKT + plain body flit -> IN_PKT.
  - Violations: a non-header flit in IDLE, or a header in IN_PKT.
  - On a violation frame_error sets and stays set until reset. The flit is still accepted, and a header restarts framing as a new packet.
- Counters: rx_flit_count increments per accepted flit; rx_pkt_count increments per accepted tail. Both wrap modulo 2^CNT_W.
- Header flit layout:
  - dst_x = flit[COORD_W-1:0].
  - dst_y = flit[2*COORD_W-1:COORD_W].
  - src_x = flit[3*COORD_W-1:2*COORD_W].
  - src_y = flit[4*COORD_W-1:3*COORD_W].
  - Upper bits are payload.
- Sink mode (macro undefined):
  - receive_ready = 1 in every cycle after reset deassertion.
  - sender_valid is held at 0; sender_flit and markers are held at 0.
  - sender_ready is ignored.

Optional Feature:
- Macro: NOC_EMPTY_NODE_ECHO_EN.
- Undefined: sink mode as above, with no FIFO logic.
- Defined: echo mode.
  - Accepted flits, with their header and tail markers, are pushed into a FIFO_DEPTH-entry FIFO.
  - receive_ready = !full. A pop in the same cycle does not make room for a push while full.
  - Outputs are show-ahead: sender_valid = !empty, and the head entry drives the sender outputs.
  - A flit accepted at edge N appears on sender outputs after edge N, so sender_valid is high in cycle N+1; one-cycle latency.
  - Header flits are echoed with the src and dst fields swapped; payload bits, body flits and the markers pass unchanged.
  - Push and pop on the same edge when neither full nor empty leave occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Framing checks and counters operate exactly as in sink mode.

Test Plan:
- Reset, then release at 100 ps -> all outputs 0 during reset; receive_ready = 1 on the first edge after release; counters = 0.
- Sink mode, 3-flit packet (header 0x0000_0012, body, tail) -> rx_flit_count = 3, rx_pkt_count = 1, frame_error = 0, sender_valid stays 0.
- Sink mode, body flit sent while IDLE -> frame_error = 1 and stays 1; rx_flit_count still increments.
- Echo mode, single-flit packet 0xAB00_00E4 (dst x0/y1, src x2/y3) -> next cycle sender_flit = 0xAB00_004E with header = 1 and tail = 1.
- Echo mode, sender_ready = 0 while 10 flits are offered -> 8 accepted, receive_ready = 0 from then on; raising sender_ready drains the flits in order and receive_ready returns to 1 after the first pop.
- Echo mode, reset asserted mid-packet -> FIFO empties, sender_valid = 0 immediately, framing returns to IDLE.
